pipeline_stall_ctrl: RTL
========================

Name: pipeline_stall_ctrl

Overview:
- Consumes the stall request from the ID-stage hazard detector, the branch-taken decision, and the data-memory busy handshake.
- Drives every freeze, flush and bubble control for the 5-stage MIPS pipeline (PC, IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Tracks stall state with a small FSM, a stall watchdog, and saturating performance counters that are readable by the debug bus.

Parameters:
- CNT_W, 16: width of each performance counter.
- WDOG_MAX, 64: number of consecutive non-RUN cycles before the watchdog fires.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- hazard_detected  in  1  load-use or branch operand hazard seen in ID this cycle
- branch_taken  in  1  ID-stage branch resolved taken (valid only when hazard_detected=0)
- mem_busy  in  1  data memory not ready; MEM stage cannot complete this cycle
- cnt_clear  in  1  synchronous clear of all counters and the sticky timeout flag
- pc_freeze  out  1  hold the PC
- if_id_freeze  out  1  hold the IF/ID register
- if_id_flush  out  1  load a NOP into IF/ID
- id_exe_bubble  out  1  load a NOP into ID/EXE
- exe_mem_freeze  out  1  hold ID/EXE and EXE/MEM
- mem_wb_bubble  out  1  load a NOP into MEM/WB
- stall_state  out  2  current FSM state code
- stall_cycles  out  CNT_W  cycles spent in HAZ_STALL
- mem_wait_cycles  out  CNT_W  cycles spent in MEM_WAIT
- flush_count  out  CNT_W  taken-branch flushes issued
- stall_timeout  out  1  sticky flag; set when the watchdog fires

Behaviour:
- Control outputs are combinational from the current-cycle inputs, giving zero-latency stalls. All other state is registered on the rising edge of clk.
- Priority 1, mem_busy=1 (whole-pipe freeze):
  - pc_freeze, if_id_freeze and exe_mem_freeze are 1; mem_wb_bubble is 1.
  - if_id_flush and id_exe_bubble are 0.
  - hazard_detected and branch_taken are ignored this cycle. Both re-evaluate once the pipe moves, because ID contents are held.
- Priority 2, hazard_detected=1 (mem_busy=0):
  - pc_freeze, if_id_freeze and id_exe_bubble are 1; all other controls are 0.
  - branch_taken is ignored because the branch operands are unresolved.
- Priority 3, branch_taken=1 (the other two inputs 0): if_id_flush=1, all other controls 0. The PC loads the branch target.
- Otherwise all control outputs are 0.
- Each cycle has exactly one winning action; freeze and flush of the same register are never asserted together.
- FSM states, with codes on stall_state:
  - RUN=2'd0, HAZ_STALL=2'd1, MEM_WAIT=2'd2, FLUSH=2'd3.
  - Next state is the priority winner of the current cycle's inputs: MEM_WAIT, HAZ_STALL, FLUSH or RUN.
  - The FSM is observational only; it never gates the combinational outputs.
- Counters, all saturating at 2^CNT_W-1 (no wrap):
  - stall_cycles increments on each cycle where hazard_detected wins.
  - mem_wait_cycles increments on each cycle where mem_busy=1.
  - flush_count increments on each cycle where branch_taken wins.
  - cnt_clear=1 zeroes all counters, the watchdog and stall_timeout at the next edge. Clear beats increment in the same cycle.
- Watchdog:
  - Counts consecutive cycles whose next state is not RUN and not FLUSH. Resets to 0 on any RUN or FLUSH cycle.
  - On reaching WDOG_MAX, sets stall_timeout=1. The flag stays set until cnt_clear or reset; the watchdog itself saturates.
- Reset (rst=0, any time, asynchronous): state=RUN, all counters=0, watchdog=0, stall_timeout=0.
  - Control outputs still follow their combinational inputs during reset. The upstream pipeline registers are themselves held in reset, so this is harmless.
  - Reset asserted mid-MEM_WAIT returns state to RUN immediately.

Decomposition:
- Shared defines file: state codes ST_RUN, ST_HAZ, ST_MEM, ST_FLUSH, and the stall_state width. These sit alongside the existing REG_FILE_ADDR_LEN and COND_* defines.
- One sub-module, sat_counter (parameter W; inputs clk, rst, clr, inc; output q). It is instantiated three times for the counters and once for the watchdog.

Test Plan:
- Reset, then hazard_detected=1 for 2 cycles → pc_freeze=if_id_freeze=id_exe_bubble=1 both cycles; stall_state=1; stall_cycles=2; flush_count=0.
- mem_busy=1 together with hazard_detected=1 and branch_taken=1 for 3 cycles → only pc_freeze, if_id_freeze, exe_mem_freeze and mem_wb_bubble are high; mem_wait_cycles=3; stall_cycles=0; flush_count=0.
- branch_taken=1 alone for 1 cycle, then hazard_detected=1 together with branch_taken=1 → cycle 1 gives if_id_flush=1 and flush_count=1; cycle 2 gives id_exe_bubble=1, if_id_flush=0, and flush_count stays 1.
- WDOG_MAX=64, mem_busy=1 for 63 cycles → stall_timeout=0. Continue to 64 cycles → stall_timeout=1. Release mem_busy → flag stays 1 until cnt_clear.
- CNT_W=4, hazard_detected=1 for 20 cycles → stall_cycles saturates at 15. cnt_clear together with hazard_detected → next value 0.
- Assert rst=0 asynchronously mid-MEM_WAIT with counters nonzero → stall_state=0, all counters and stall_timeout=0 before the next clk edge.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: FSM state codes and
// widths used by the hazard/flush control logic.
package pipeline_stall_ctrl_pkg;

  localparam int REG_FILE_ADDR_LEN = 5;
  localparam int STALL_STATE_W     = 2;

  typedef enum logic [STALL_STATE_W-1:0] {
    ST_RUN   = 2'd0,
    ST_HAZ   = 2'd1,
    ST_MEM   = 2'd2,
    ST_FLUSH = 2'd3
  } stall_state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Up-counter that sticks at its all-ones value; clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = '1;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == MAX) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= sat_inc(q);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Zero-latency freeze/flush/bubble generator for the 5-stage pipeline, with an
// observational stall FSM, a stall watchdog and saturating perf counters.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WDOG_MAX = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hazard_detected,
  input  logic                     branch_taken,
  input  logic                     mem_busy,
  input  logic                     cnt_clear,
  output logic                     pc_freeze,
  output logic                     if_id_freeze,
  output logic                     if_id_flush,
  output logic                     id_exe_bubble,
  output logic                     exe_mem_freeze,
  output logic                     mem_wb_bubble,
  output logic [STALL_STATE_W-1:0] stall_state,
  output logic [CNT_W-1:0]         stall_cycles,
  output logic [CNT_W-1:0]         mem_wait_cycles,
  output logic [CNT_W-1:0]         flush_count,
  output logic                     stall_timeout
);

  localparam int                WDOG_W    = $clog2(WDOG_MAX + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_MAX - 1);

  stall_state_e      state_p1;
  stall_state_e      next_p0;
  logic              wdog_inc;
  logic [WDOG_W-1:0] wdog_q;

  // Stage p0: priority resolution of this cycle's inputs (mem > hazard > branch)
  always_comb begin
    pc_freeze      = 1'b0;
    if_id_freeze   = 1'b0;
    if_id_flush    = 1'b0;
    id_exe_bubble  = 1'b0;
    exe_mem_freeze = 1'b0;
    mem_wb_bubble  = 1'b0;
    next_p0        = ST_RUN;
    if (mem_busy) begin
      pc_freeze      = 1'b1;
      if_id_freeze   = 1'b1;
      exe_mem_freeze = 1'b1;
      mem_wb_bubble  = 1'b1;
      next_p0        = ST_MEM;
    end else if (hazard_detected) begin
      pc_freeze      = 1'b1;
      if_id_freeze   = 1'b1;
      id_exe_bubble  = 1'b1;
      next_p0        = ST_HAZ;
    end else if (branch_taken) begin
      if_id_flush    = 1'b1;
      next_p0        = ST_FLUSH;
    end
  end

  // Stage p1: registered state, counters and watchdog
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p1 <= ST_RUN;
    end else begin
      state_p1 <= next_p0;
    end
  end

  assign stall_state = state_p1;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk), .rst (rst), .clr (cnt_clear),
    .inc (next_p0 == ST_HAZ), .q (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_mem_cnt (
    .clk (clk), .rst (rst), .clr (cnt_clear),
    .inc (next_p0 == ST_MEM), .q (mem_wait_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk), .rst (rst), .clr (cnt_clear),
    .inc (next_p0 == ST_FLUSH), .q (flush_count)
  );

  // Any RUN or FLUSH cycle breaks the run of consecutive stalls
  assign wdog_inc = (next_p0 == ST_HAZ) || (next_p0 == ST_MEM);

  sat_counter #(.W(WDOG_W)) u_wdog (
    .clk (clk), .rst (rst), .clr (cnt_clear || !wdog_inc),
    .inc (wdog_inc), .q (wdog_q)
  );

  // Flag rises on the same edge the watchdog count reaches WDOG_MAX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_timeout <= 1'b0;
    end else if (cnt_clear) begin
      stall_timeout <= 1'b0;
    end else if (wdog_inc && (wdog_q >= WDOG_LAST)) begin
      stall_timeout <= 1'b1;
    end
  end

endmodule
